uart_tx_gen: RTL and testbench

UART_TX_GEN -- requirements
Module: uart_tx_gen

---
 rtl/uart_tx_gen.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_gen.sv
// uart_tx_gen -- parameterised UART transmitter (start, data LSB first,
// optional parity, 1 or 2 stop bits).
//
// Bit time is DIV = CLK_FREQ / BAUD_RATE clk cycles, counted with a clock
// enable style counter; no derived clock is generated.
//
// Optional feature:
//   UART_TX_PARITY_EN  when defined, a parity bit (even, or odd when
//                      PARITY_ODD=1) follows the last data bit. When
//                      undefined, STOP follows DATA and PARITY_ODD is ignored.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   tx_valid  in   tx_data holds a word to send
//   tx_data   in   [DATA_BITS-1:0] word to transmit
//   tx_ready  out  a word can be accepted this cycle (IDLE and not in reset)
//   tx        out  serial line, idles high
//   busy      out  high while a frame is on the line
//   done      out  one-cycle pulse in the first IDLE cycle after a frame

module uart_tx_gen #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int DIV      = CLK_FREQ / BAUD_RATE;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CNT_W    = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_LEN - 1);
    localparam logic [3:0]       LAST_IDX = 4'(DATA_BITS - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_tx_gen: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_chk
        $error("uart_tx_gen: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
        $error("uart_tx_gen: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_par_chk
        $error("uart_tx_gen: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;      // cycles within the current bit (or whole stop period)
    logic [3:0]           bit_idx;  // index of the data bit currently on the line
    logic [DATA_BITS-1:0] shreg;    // remaining data bits, next one in bit 0
`ifdef UART_TX_PARITY_EN
    logic                 par;      // parity captured with the word
`endif

    assign tx_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // rst is low in this branch, so tx_ready equals IDLE here
                    if (tx_valid) begin
                        state   <= START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        bit_idx <= '0;
                        shreg   <= tx_data;
`ifdef UART_TX_PARITY_EN
                        par     <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
                    end
                end

                START: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    // the whole stop period is counted in one run of STOP_BITS*DIV cycles
                    if (cnt == STOP_END) begin
                        cnt   <= '0;
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed bench for uart_tx_gen.
// dut0: 8 data bits, 1 stop bit, DIV=4.
// dut1: 7 data bits, 2 stop bits, DIV=4, PARITY_ODD=1.
// Expected frames are written as strings, one character per bit time.

module tb_uart_tx_gen;

    logic       clk = 1'b0;
    logic       rst;

    logic       tx_valid0, tx_ready0, tx0, busy0, done0;
    logic [7:0] tx_data0;
    logic       tx_valid1, tx_ready1, tx1, busy1, done1;
    logic [6:0] tx_data1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_gen #(
        .CLK_FREQ  (1000000),
        .BAUD_RATE (250000),
        .DATA_BITS (8),
        .STOP_BITS (1),
        .PARITY_ODD(0)
    ) dut0 (
        .clk     (clk),
        .rst     (rst),
        .tx_valid(tx_valid0),
        .tx_data (tx_data0),
        .tx_ready(tx_ready0),
        .tx      (tx0),
        .busy    (busy0),
        .done    (done0)
    );

    uart_tx_gen #(
        .CLK_FREQ  (1000000),
        .BAUD_RATE (250000),
        .DATA_BITS (7),
        .STOP_BITS (2),
        .PARITY_ODD(1)
    ) dut1 (
        .clk     (clk),
        .rst     (rst),
        .tx_valid(tx_valid1),
        .tx_data (tx_data1),
        .tx_ready(tx_ready1),
        .tx      (tx1),
        .busy    (busy1),
        .done    (done1)
    );

`ifdef UART_TX_PARITY_EN
    localparam string EXP_A5 = "01010010101";
    localparam string EXP_41 = "01000001111";
    localparam string EXP_55 = "01010101001";
    localparam string EXP_AA = "00101010101";
    localparam string EXP_00 = "00000000001";
`else
    localparam string EXP_A5 = "0101001011";
    localparam string EXP_41 = "0100000111";
    localparam string EXP_55 = "0101010101";
    localparam string EXP_AA = "0010101011";
    localparam string EXP_00 = "0000000001";
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic o_tx(input int sel);
        return (sel == 1) ? tx1 : tx0;
    endfunction
    function automatic logic o_busy(input int sel);
        return (sel == 1) ? busy1 : busy0;
    endfunction
    function automatic logic o_done(input int sel);
        return (sel == 1) ? done1 : done0;
    endfunction
    function automatic logic o_ready(input int sel);
        return (sel == 1) ? tx_ready1 : tx_ready0;
    endfunction

    // Presents one word for one edge, then scrambles tx_data so any late
    // sampling of the input shows up in the frame.
    task automatic accept(input int sel, input logic [8:0] data, input string tag);
        if (sel == 1) begin
            tx_valid1 = 1'b1;
            tx_data1  = data[6:0];
        end else begin
            tx_valid0 = 1'b1;
            tx_data0  = data[7:0];
        end
        chk({tag, "_ready"}, o_ready(sel), 1'b1);
        tick();
        if (sel == 1) begin
            tx_valid1 = 1'b0;
            tx_data1  = ~data[6:0];
        end else begin
            tx_valid0 = 1'b0;
            tx_data0  = ~data[7:0];
        end
    endtask

    // Called in the first cycle after acceptance; returns in the done cycle.
    task automatic frame(input int sel, input string exp, input string tag);
        int ncyc;
        ncyc = exp.len() * 4;
        for (int k = 0; k < ncyc; k++) begin
            chk($sformatf("%s_tx_c%0d", tag, k + 1), o_tx(sel), exp.getc(k / 4) == "1");
            chk($sformatf("%s_busy_c%0d", tag, k + 1), o_busy(sel), 1'b1);
            chk($sformatf("%s_done_c%0d", tag, k + 1), o_done(sel), 1'b0);
            chk($sformatf("%s_rdy_c%0d", tag, k + 1), o_ready(sel), 1'b0);
            tick();
        end
        chk({tag, "_done"}, o_done(sel), 1'b1);
        chk({tag, "_busy_end"}, o_busy(sel), 1'b0);
        chk({tag, "_tx_end"}, o_tx(sel), 1'b1);
        chk({tag, "_rdy_end"}, o_ready(sel), 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        tx_valid0 = 1'b0;
        tx_data0  = '0;
        tx_valid1 = 1'b0;
        tx_data1  = '0;

        // reset state
        tick();
        tick();
        chk("rst_tx", tx0, 1'b1);
        chk("rst_ready", tx_ready0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_ready1", tx_ready1, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", tx_ready0, 1'b1);
        tick();

        // 8-bit frame of 0xA5
        accept(0, 9'h0A5, "a5");
        frame(0, EXP_A5, "a5");
        tick();
        chk("a5_done_one_cycle", done0, 1'b0);

        // 7 data bits, 2 stop bits, 0x41
        accept(1, 9'h041, "w7");
        frame(1, EXP_41, "w7");
        tick();
        chk("w7_done_one_cycle", done1, 1'b0);

        // back-to-back: tx_valid stays high through both frames
        tx_valid0 = 1'b1;
        tx_data0  = 8'h55;
        chk("b2b_ready", tx_ready0, 1'b1);
        tick();
        tx_data0 = 8'hAA;
        frame(0, EXP_55, "b2b55");
        tick();
        tx_valid0 = 1'b0;
        tx_data0  = 8'h00;
        frame(0, EXP_AA, "b2bAA");
        tick();
        chk("b2b_idle_done", done0, 1'b0);
        chk("b2b_idle_busy", busy0, 1'b0);

        // reset during data bit 3 of 0xFF (cycles 17..20 of the frame)
        accept(0, 9'h0FF, "rf");
        for (int i = 0; i < 17; i++) tick();
        chk("rf_busy_mid", busy0, 1'b1);
        chk("rf_tx_mid", tx0, 1'b1);
        rst       = 1'b1;
        tx_valid0 = 1'b1;
        tx_data0  = 8'h12;
        tick();
        chk("rf_tx_after", tx0, 1'b1);
        chk("rf_busy_after", busy0, 1'b0);
        chk("rf_done_after", done0, 1'b0);
        chk("rf_ready_in_rst", tx_ready0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rf_hold_done%0d", i), done0, 1'b0);
            chk($sformatf("rf_hold_busy%0d", i), busy0, 1'b0);
            chk($sformatf("rf_hold_tx%0d", i), tx0, 1'b1);
        end
        tx_valid0 = 1'b0;
        rst       = 1'b0;
        #1;
        chk("rf_ready_release", tx_ready0, 1'b1);
        tick();
        chk("rf_no_done", done0, 1'b0);
        chk("rf_idle_busy", busy0, 1'b0);

        accept(0, 9'h000, "z");
        frame(0, EXP_00, "z");
        tick();
        chk("z_done_one_cycle", done0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
